multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter-free ports; widths are fixed by the shared constants in REQ-024.
REQ-002 Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the Clk rising edge.
REQ-004 Qin  input  5  quotient operand (multiplier count), unsigned.
REQ-005 Yin  input  7  divisor operand (multiplicand), unsigned.
REQ-006 Rin  input  5  remainder operand (addend), unsigned.
REQ-007 Start  input  1  request; sampled only in INITIAL.
REQ-008 Ack  input  1  result acknowledge; sampled only in DONE_S.
REQ-009 Product  output  12  result Qin*Yin+Rin, driven straight from the accumulator register.
REQ-010 Done  output  1  high exactly while in DONE_S.
REQ-011 Qi, Qc, Qd  output  1 each  one-hot state flags for INITIAL, COMPUTE and DONE_S.

Function
REQ-012 SHALL reconstruct a dividend from a divider result: Product = Qin*Yin + Rin, computed by repeated addition.
REQ-013 SHALL use a 3-state one-hot FSM with encodings INITIAL=3'b001, COMPUTE=3'b010, DONE_S=3'b100, and {Qd,Qc,Qi} = state.
REQ-014 INITIAL: every cycle load Acc<=Rin (zero-extended), Cnt<=Qin, Yr<=Yin; if Start, go to COMPUTE, else stay.
REQ-015 COMPUTE: if Cnt!=0, Acc<=Acc+Yr and Cnt<=Cnt-1.
REQ-016 COMPUTE: if Cnt<=1, go to DONE_S on the same edge; otherwise stay.
REQ-017 Cycles spent in COMPUTE SHALL equal max(Qin,1); Qin=0 gives one COMPUTE cycle with no addition.
REQ-018 DONE_S: Acc, Cnt and Yr hold; go to INITIAL when Ack=1, else stay indefinitely.
REQ-019 Qin, Yin, Rin and Start changes during COMPUTE or DONE_S SHALL have no effect.
REQ-020 Acc SHALL be 12 bits wide; the maximum result 31*127+31=3968 fits, so no overflow handling is required.
REQ-021 Product SHALL equal the operand-loaded Rin while in INITIAL (after the first INITIAL cycle), SHALL show partial sums during COMPUTE, and SHALL be final and stable throughout DONE_S.

Reset
REQ-022 On Reset=1 at a Clk edge, in any state including mid-COMPUTE: state<=INITIAL, Acc<=0, Cnt<=0, Yr<=0.
REQ-023 Output values after reset SHALL be: Product=0, Done=0, Qi=1, Qc=0, Qd=0; Reset SHALL take priority over Start and Ack.

Structure
REQ-024 The state encodings and the operand and result widths (5/7/5/12) SHALL live in the shared header divmul_defs.vh, which the divider also uses.
REQ-025 SHALL be a single module with one clocked always block that combines the control unit and the datapath; no sub-module.

Verification
REQ-026 Qin=5, Yin=7, Rin=3, Start pulse -> 5 cycles with Qc=1, then Done=1 and Product=38; Ack -> Qi=1 on the next cycle.
REQ-027 Qin=0, Yin=100, Rin=9 -> exactly 1 COMPUTE cycle, then Product=9 and Done=1.
REQ-028 Qin=31, Yin=127, Rin=31 -> 31 COMPUTE cycles, then Product=3968 with no wrap.
REQ-029 Ack held low for 10 cycles in DONE_S -> Product and Done stay stable; operand changes during COMPUTE do not alter the result.
REQ-030 Reset asserted in the 3rd COMPUTE cycle of the Qin=20 case -> next cycle Qi=1, Done=0, Product=0.
REQ-031 Back-to-back runs with Start held high through Ack -> a new operation starts on the first INITIAL cycle, using the operands present in that cycle.

Source files
------------

// File: rtl/multiplier_pkg.sv
// ----------------------------------------------------------------------------
// multiplier_pkg
// Shared definitions for the divider/multiplier pair: operand and result
// widths and the one-hot control-state encoding. The divider imports the same
// package so both blocks agree on widths and state flag ordering.
// ----------------------------------------------------------------------------
package multiplier_pkg;

   localparam int unsigned Q_W = 5;   // quotient / multiplier count
   localparam int unsigned Y_W = 7;   // divisor / multiplicand
   localparam int unsigned R_W = 5;   // remainder / addend
   localparam int unsigned P_W = 12;  // reconstructed dividend (31*127+31 = 3968)

   // One-hot encoding; bit order matches the {Qd, Qc, Qi} flag outputs.
   typedef enum logic [2:0] {
      ST_INITIAL = 3'b001,
      ST_COMPUTE = 3'b010,
      ST_DONE    = 3'b100
   } state_e;

endpackage : multiplier_pkg

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// multiplier
// Reconstructs a dividend from a divider result, Product = Qin*Yin + Rin, by
// repeated addition of the multiplicand Qin times into an accumulator seeded
// with the remainder.
//
// Ports
//   Clk      : single clock, rising edge
//   Reset    : synchronous, active-high; wins over Start and Ack
//   Qin      : multiplier count (5 b, unsigned), loaded in INITIAL
//   Yin      : multiplicand (7 b, unsigned), loaded in INITIAL
//   Rin      : addend (5 b, unsigned), loaded in INITIAL
//   Start    : begin computation; sampled only in INITIAL
//   Ack      : result consumed; sampled only in DONE
//   Product  : accumulator register (12 b)
//   Done     : high while in DONE
//   Qi/Qc/Qd : one-hot state flags for INITIAL / COMPUTE / DONE
// ----------------------------------------------------------------------------
module multiplier
   import multiplier_pkg::*;
(
   input  logic           Clk,
   input  logic           Reset,
   input  logic [Q_W-1:0] Qin,
   input  logic [Y_W-1:0] Yin,
   input  logic [R_W-1:0] Rin,
   input  logic           Start,
   input  logic           Ack,
   output logic [P_W-1:0] Product,
   output logic           Done,
   output logic           Qi,
   output logic           Qc,
   output logic           Qd
);

   state_e         state_q, state_d;
   logic [P_W-1:0] acc_q,   acc_d;
   logic [Q_W-1:0] cnt_q,   cnt_d;
   logic [Y_W-1:0] yr_q,    yr_d;

   // Combined control and datapath next-state logic.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      yr_d    = yr_q;

      unique case (state_q)
         ST_INITIAL: begin
            // Operands are captured every idle cycle, so the values present in
            // the cycle Start is seen are the ones used.
            acc_d = {{(P_W-R_W){1'b0}}, Rin};
            cnt_d = Qin;
            yr_d  = Yin;
            if (Start) state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            if (cnt_q != '0) begin
               acc_d = acc_q + {{(P_W-Y_W){1'b0}}, yr_q};
               cnt_d = cnt_q - 1'b1;
            end
            // Leaving on the last addition (or immediately for Qin=0) gives
            // max(Qin,1) cycles in COMPUTE.
            if (cnt_q <= Q_W'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (Ack) state_d = ST_INITIAL;
         end
         default: state_d = ST_INITIAL;
      endcase
   end

   // Single clocked process holding both control state and datapath.
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (Reset) begin
         state_q <= ST_INITIAL;
         acc_q   <= '0;
         cnt_q   <= '0;
         yr_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         yr_q    <= yr_d;
      end
   end

   assign Product      = acc_q;
   assign Done         = (state_q == ST_DONE);
   assign {Qd, Qc, Qi} = state_q;

endmodule : multiplier

// File: tb/tb_multiplier.sv
// ----------------------------------------------------------------------------
// tb_multiplier
// Directed bench for multiplier. Expected products are pushed to a scoreboard
// queue when an operation is launched and popped when Done is observed.
// ----------------------------------------------------------------------------
module tb_multiplier;
   import multiplier_pkg::*;

   logic           Clk = 1'b0;
   logic           Reset;
   logic [Q_W-1:0] Qin;
   logic [Y_W-1:0] Yin;
   logic [R_W-1:0] Rin;
   logic           Start;
   logic           Ack;
   logic [P_W-1:0] Product;
   logic           Done;
   logic           Qi, Qc, Qd;

   int checks = 0;
   int errors = 0;
   logic [P_W-1:0] exp_q[$];

   multiplier dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Qin     (Qin),
      .Yin     (Yin),
      .Rin     (Rin),
      .Start   (Start),
      .Ack     (Ack),
      .Product (Product),
      .Done    (Done),
      .Qi      (Qi),
      .Qc      (Qc),
      .Qd      (Qd)
   );

   always #5 Clk = ~Clk;

   // Advance one clock and settle past the edge before sampling.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch one operation from INITIAL and follow it to completion.
   //   hold       : cycles to keep Ack low in DONE while checking stability
   //   scramble   : drive random operands/Start during COMPUTE
   //   keep_start : leave Start high throughout (back-to-back operation)
   task automatic run_op(input int q, input int y, input int r, input int hold,
                         input bit scramble, input bit keep_start);
      int n;
      int exp_cycles;
      logic [P_W-1:0] exp_p;
      Qin   = Q_W'(q);
      Yin   = Y_W'(y);
      Rin   = R_W'(r);
      Start = 1'b1;
      exp_q.push_back(P_W'(q * y + r));
      exp_cycles = (q == 0) ? 1 : q;
      tick();
      if (!keep_start) Start = 1'b0;
      check($sformatf("enter_compute q=%0d", q), int'(Qc), 1);
      n = 0;
      while (Qc === 1'b1 && n < 100) begin
         if (scramble) begin
            Qin = Q_W'($urandom);
            Yin = Y_W'($urandom);
            Rin = R_W'($urandom);
            if (!keep_start) Start = 1'($urandom);
         end
         n++;
         tick();
      end
      if (!keep_start) Start = 1'b0;
      check($sformatf("compute_cycles q=%0d", q), n, exp_cycles);
      check($sformatf("done q=%0d", q), int'(Done), 1);
      check($sformatf("qd q=%0d", q), int'(Qd), 1);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         exp_p = '0;
      end else begin
         exp_p = exp_q.pop_front();
      end
      check($sformatf("product q=%0d y=%0d r=%0d", q, y, r), int'(Product), int'(exp_p));
      for (int i = 0; i < hold; i++) begin
         Qin = Q_W'($urandom);
         Yin = Y_W'($urandom);
         Rin = R_W'($urandom);
         tick();
         check($sformatf("hold_product cyc=%0d", i), int'(Product), int'(exp_p));
         check($sformatf("hold_done cyc=%0d", i), int'(Done), 1);
      end
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      check($sformatf("ack_to_initial q=%0d", q), int'(Qi), 1);
      check($sformatf("done_low_after_ack q=%0d", q), int'(Done), 0);
   endtask

   initial begin
      // Reset with Start and Ack also high: reset must win.
      Reset = 1'b1;
      Start = 1'b1;
      Ack   = 1'b1;
      Qin   = 5'd5;
      Yin   = 7'd7;
      Rin   = 5'd3;
      tick();
      tick();
      check("reset_product", int'(Product), 0);
      check("reset_done", int'(Done), 0);
      check("reset_flags", int'({Qd, Qc, Qi}), 3'b001);
      Reset = 1'b0;
      Start = 1'b0;
      Ack   = 1'b0;

      // Idle in INITIAL: Product follows the loaded Rin.
      tick();
      check("initial_loads_rin", int'(Product), 3);
      check("initial_stays", int'(Qi), 1);

      // Basic case 5*7+3 = 38, then 10-cycle Ack-low hold with operand churn.
      run_op(5, 7, 3, 10, 1'b0, 1'b0);

      // Qin = 0: single COMPUTE cycle, result is Rin.
      run_op(0, 100, 9, 0, 1'b0, 1'b0);

      // Maximum operands: 31*127+31 = 3968, no wrap.
      run_op(31, 127, 31, 2, 1'b0, 1'b0);

      // Operand changes during COMPUTE must not alter the result.
      run_op(12, 45, 17, 3, 1'b1, 1'b0);
      run_op(1, 127, 0, 1, 1'b1, 1'b0);

      // Reset in the 3rd COMPUTE cycle of a Qin=20 run, with Start high too.
      Qin   = 5'd20;
      Yin   = 7'd50;
      Rin   = 5'd4;
      Start = 1'b1;
      tick();            // now in COMPUTE cycle 1
      Start = 1'b0;
      tick();            // cycle 2
      tick();            // cycle 3
      check("mid_compute_before_reset", int'(Qc), 1);
      Reset = 1'b1;
      Start = 1'b1;
      tick();
      Reset = 1'b0;
      Start = 1'b0;
      check("midreset_qi", int'(Qi), 1);
      check("midreset_qc", int'(Qc), 0);
      check("midreset_done", int'(Done), 0);
      check("midreset_product", int'(Product), 0);
      tick();            // one idle cycle so the next run starts cleanly

      // Back-to-back runs with Start held high through Ack: the next op
      // starts from the first INITIAL cycle with operands driven there.
      run_op(3, 11, 2, 0, 1'b0, 1'b1);
      run_op(4, 9, 1, 0, 1'b1, 1'b1);
      run_op(2, 100, 30, 0, 1'b0, 1'b1);
      Start = 1'b0;
      tick();
      check("idle_after_b2b", int'(Qi), 1);

      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_multiplier
